// File: rtl/err_demod_gen.sv
// err_demod_gen: square-wave modulator with synchronous demodulation into a signed error word
// Ports: i_clk / i_rst_n (async, active-low) clock and reset; i_en enable; i_adc signed 14-bit sample;
//        i_freq half-period F, i_wait_cnt settle count W, i_avg_sel log2 of sample count N, i_polarity error sign;
//        o_mod square wave (1 = positive half); o_err / o_trig error word and its one-cycle strobe;
//        o_cfg_err set for a period whose W+N exceeds F; o_avg_pos / o_avg_neg latest half-period averages.
module err_demod_gen (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic signed [13:0] i_adc,
    input  logic [15:0]        i_freq,
    input  logic [15:0]        i_wait_cnt,
    input  logic [3:0]         i_avg_sel,
    input  logic               i_polarity,
    output logic               o_mod,
    output logic signed [31:0] o_err,
    output logic               o_trig,
    output logic               o_cfg_err,
    output logic signed [31:0] o_avg_pos,
    output logic signed [31:0] o_avg_neg
);
    typedef enum logic [1:0] {WAIT, ACCUM, DONE} state_t;

    state_t             st_q, st, st_d;
    logic [15:0]        cnt_q, f_q, w_q, f, w;
    logic [3:0]         sel_q, sel_in, sel;
    logic [16:0]        end_cnt;
    logic               mod_q, pol_q, cfg_q, cfg, cfg_bad, latch, take, last, wrap;
    logic               store_pos_q, store_neg_q, err_pend_q, trig_q;
    logic signed [31:0] acc_q, acc, acc_d, avg_new, avg_pos_q, avg_neg_q, err_q, err_nxt_q;

    always_comb begin
        // On the first clock of a period the live inputs govern; they are latched for the rest of it
        latch   = cnt_q == 16'd0 && mod_q;
        sel_in  = i_avg_sel > 4'd10 ? 4'd10 : i_avg_sel;
        f       = latch ? i_freq : f_q;
        w       = latch ? i_wait_cnt : w_q;
        sel     = latch ? sel_in : sel_q;
        end_cnt = {1'b0, w} + (17'd1 << sel);
        cfg_bad = end_cnt > {1'b0, f};
        cfg     = latch ? cfg_bad : cfg_q;
        wrap    = cnt_q == f - 16'd1;
        // A half-period edge restarts the FSM from an empty accumulator on this very clock
        st      = cnt_q == 16'd0 ? WAIT : st_q;
        acc     = cnt_q == 16'd0 ? 32'sd0 : acc_q;
        take    = !cfg && ((st == WAIT && cnt_q == w) || st == ACCUM);
        last    = take && ({1'b0, cnt_q} + 17'd1 == end_cnt);
        acc_d   = take ? acc + 32'(i_adc) : acc;
        st_d    = last ? DONE : take ? ACCUM : st;
        avg_new = acc_q >>> sel_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            mod_q       <= 1'b1;
            st_q        <= WAIT;
            acc_q       <= '0;
            f_q         <= 16'd100;
            w_q         <= 16'd10;
            sel_q       <= 4'd3;
            pol_q       <= 1'b0;
            cfg_q       <= 1'b0;
            store_pos_q <= 1'b0;
            store_neg_q <= 1'b0;
            err_pend_q  <= 1'b0;
            trig_q      <= 1'b0;
            avg_pos_q   <= '0;
            avg_neg_q   <= '0;
            err_q       <= '0;
            err_nxt_q   <= '0;
        end else if (!i_en) begin
            cnt_q       <= '0;
            mod_q       <= 1'b1;
            st_q        <= WAIT;
            acc_q       <= '0;
            store_pos_q <= 1'b0;
            store_neg_q <= 1'b0;
            err_pend_q  <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            cnt_q       <= wrap ? 16'd0 : cnt_q + 16'd1;
            mod_q       <= mod_q ^ wrap;
            if (latch) begin
                f_q   <= i_freq;
                w_q   <= i_wait_cnt;
                sel_q <= sel_in;
                pol_q <= i_polarity;
                cfg_q <= cfg_bad;
            end
            st_q        <= st_d;
            acc_q       <= acc_d;
            store_pos_q <= last && mod_q;
            store_neg_q <= last && !mod_q;
            err_pend_q  <= store_neg_q;
            trig_q      <= err_pend_q;
            if (store_pos_q)
                avg_pos_q <= avg_new;
            // The difference is formed with the polarity of the period that produced the data,
            // even when the store lands on the latch clock of the next period
            if (store_neg_q) begin
                avg_neg_q <= avg_new;
                err_nxt_q <= pol_q ? avg_new - avg_pos_q : avg_pos_q - avg_new;
            end
            if (err_pend_q)
                err_q <= err_nxt_q;
        end
    end

    assign o_mod     = mod_q;
    assign o_err     = err_q;
    assign o_trig    = trig_q;
    assign o_cfg_err = cfg_q;
    assign o_avg_pos = avg_pos_q;
    assign o_avg_neg = avg_neg_q;
endmodule

// File: tb/tb_err_demod_gen.sv
// tb_err_demod_gen: randomized and directed checking of err_demod_gen against a period-level event model
module tb_err_demod_gen;
    logic               clk = 1'b0, rst_n = 1'b0, en = 1'b0, pol = 1'b0;
    logic signed [13:0] adc = 14'sd100;
    logic [15:0]        freq = 16'd16, wcnt = 16'd4;
    logic [3:0]         sel = 4'd2;
    logic               o_mod, o_trig, o_cfg_err;
    logic signed [31:0] o_err, o_avg_pos, o_avg_neg;

    err_demod_gen dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_adc(adc), .i_freq(freq), .i_wait_cnt(wcnt),
        .i_avg_sel(sel), .i_polarity(pol), .o_mod(o_mod), .o_err(o_err), .o_trig(o_trig),
        .o_cfg_err(o_cfg_err), .o_avg_pos(o_avg_pos), .o_avg_neg(o_avg_neg)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each period is latched once, then its stores and trig are scheduled as timed events
    typedef struct {int at; int kind; int base; int n; int sh; bit pol;} ev_t;
    ev_t evq[$];
    int  hist[8192];
    int  k = 0, start = 0, lf = 100, lw = 10, lsel = 3, rel = 0;
    bit  lpol = 0, m_mod = 1, m_trig = 0, m_cfg = 0;
    int  m_err = 0, m_pos = 0, m_neg = 0;
    int  tq[$];
    int  adc_mode = 1, ap = 100, an = -100;

    function automatic int avg_of(input int base, input int n, input int sh);
        longint s = 0;
        for (int i = 0; i < n; i++)
            s += longint'(hist[(base + i) % 8192]);
        return int'(s >>> sh);
    endfunction

    task automatic model_edge();
        int i, n;
        if (!rst_n) begin
            evq.delete();
            m_mod = 1; m_trig = 0; m_cfg = 0; m_err = 0; m_pos = 0; m_neg = 0;
            lf = 100; lw = 10; lsel = 3; lpol = 0; start = k + 1;
        end else if (!en) begin
            evq.delete();
            m_mod = 1; m_trig = 0; start = k + 1;
        end else begin
            hist[k % 8192] = int'(adc);
            if (k == start) begin
                lf = int'(freq); lw = int'(wcnt); lsel = sel > 10 ? 10 : int'(sel); lpol = pol;
                n = 1 << lsel;
                m_cfg = lw + n > lf;
                if (!m_cfg) begin
                    evq.push_back('{start + lw + n, 0, start + lw, n, lsel, lpol});
                    evq.push_back('{start + lf + lw + n, 1, start + lf + lw, n, lsel, lpol});
                    evq.push_back('{start + lf + lw + n + 1, 2, 0, 0, 0, lpol});
                end
            end
            m_trig = 0;
            i = 0;
            while (i < evq.size()) begin
                if (evq[i].at == k) begin
                    if (evq[i].kind == 0) m_pos = avg_of(evq[i].base, evq[i].n, evq[i].sh);
                    else if (evq[i].kind == 1) m_neg = avg_of(evq[i].base, evq[i].n, evq[i].sh);
                    else begin
                        m_trig = 1;
                        m_err = evq[i].pol ? m_neg - m_pos : m_pos - m_neg;
                    end
                    evq.delete(i);
                end else i++;
            end
            if (k + 1 == start + 2 * lf) start = k + 1;
            m_mod = (k + 1 - start) < lf;
        end
        k++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("trig", o_trig, m_trig);
        check("mod", o_mod, m_mod);
        check("cfg_err", o_cfg_err, m_cfg);
        check("err", o_err, m_err);
        check("avg_pos", o_avg_pos, m_pos);
        check("avg_neg", o_avg_neg, m_neg);
        if (o_trig) tq.push_back(k - 1);
        if (adc_mode == 1) adc = 14'(m_mod ? ap : an);
        else if (adc_mode == 2) adc = 14'($urandom_range(0, 16383));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    function automatic int tq_at(input int i);
        return i < tq.size() ? tq[i] : -1;
    endfunction

    task automatic wait_neg5();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            found = (k - start >= lf) && (k - start - lf == 5);
        end
        check("neg5_found", found, 1);
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        check("rst_async_trig", o_trig, 0);
        check("rst_async_err", o_err, 0);
        check("rst_async_mod", o_mod, 1);
        check("rst_async_pos", o_avg_pos, 0);
        run(hold);
        rst_n = 1'b1;
        rel = k;
        tq.delete();
    endtask

    initial begin
        run(3);
        en = 1'b1;
        rst_n = 1'b1;
        rel = k;
        tq.delete();
        run(100);
        check("first_trig", tq_at(0) - rel, 25);
        check("trig_gap", tq_at(1) - tq_at(0), 32);
        check("err_p0", o_err, 200);
        check("cfg_ok", o_cfg_err, 0);

        pol = 1'b1;
        run(100);
        check("err_p1", o_err, -200);
        check("pos_100", o_avg_pos, 100);
        check("neg_m100", o_avg_neg, -100);

        freq = 16'd8; wcnt = 16'd6;
        run(64);
        tq.delete();
        run(48);
        check("cfg_set", o_cfg_err, 1);
        check("no_trig", tq.size(), 0);
        check("err_hold", o_err, -200);
        wcnt = 16'd2;
        tq.delete();
        run(48);
        check("trig_resume", tq.size() > 0, 1);

        freq = 16'd16; wcnt = 16'd4; pol = 1'b0;
        run(80);
        wait_neg5();
        rel = tq_at(tq.size() - 1);
        tq.delete();
        freq = 16'd20;
        run(150);
        check("gap_old", tq_at(0) - rel, 32);
        check("gap_new", tq_at(2) - tq_at(1), 40);

        freq = 16'd16;
        run(80);
        wait_neg5();
        do_reset(3);
        run(70);
        check("rst_first_trig", tq_at(0) - rel, 25);
        check("rst_gap", tq_at(1) - tq_at(0), 32);
        check("rst_err", o_err, 200);

        en = 1'b0;
        run(6);
        check("dis_mod", o_mod, 1);
        en = 1'b1;
        freq = 16'd2000; wcnt = 16'd0; sel = 4'd10; ap = -8192; an = 8191;
        run(8100);
        check("ext_err", o_err, -16383);
        sel = 4'd13;
        run(8100);
        check("clamp_err", o_err, -16383);
        check("clamp_cfg", o_cfg_err, 0);

        adc_mode = 2;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                freq = 16'($urandom_range(4, 24));
                wcnt = 16'($urandom_range(0, 12));
                sel  = $urandom_range(0, 7) == 0 ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 4));
                pol  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 299) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            if ($urandom_range(0, 1999) == 0) do_reset(2);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
